// File: rtl/binary_to_bcd_seq.sv
// binary_to_bcd_seq
// Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble)
// method. One operand bit is consumed per clock through a single shared
// adjust-and-shift datapath. A three-state controller sequences the work:
// IDLE accepts a request, CONVERT iterates, and DONE pulses the done flag.

module binary_to_bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [WIDTH-1:0]      i_bin,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [4*DIGITS-1:0]   o_bcd
);

   localparam int CNTW = $clog2(WIDTH + 1);
   localparam int BCDW = 4 * DIGITS;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      CONVERT = 2'b01,
      DONE    = 2'b10
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [WIDTH-1:0]  r_shiftReg;
   logic [BCDW-1:0]   r_acc;
   logic [CNTW-1:0]   r_cnt;
   logic [BCDW-1:0]   r_bcd;
   logic [BCDW-1:0]   w_accAdj;
   logic [BCDW-1:0]   w_accShift;
   logic              w_lastIter;

   // The final iteration is the one that starts with a single bit left to consume.
   assign w_lastIter = (r_cnt == CNTW'(1));

   // Add 3 to every digit that is 5 or more, so that the coming shift carries
   // correctly into the next decimal digit. The adjusted digit is never above 12,
   // so no carry ever crosses a digit boundary.
   always_comb begin
      w_accAdj = r_acc;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_acc[4*d +: 4] >= 4'd5) begin
            w_accAdj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
         end
      end
   end

   // Shift the adjusted accumulator left by one. The next operand bit, taken
   // from the MSB of the shift register, enters at bit 0.
   always_comb begin
      w_accShift = (w_accAdj << 1) | {{(BCDW-1){1'b0}}, r_shiftReg[WIDTH-1]};
   end

   // State register. Reset and any unused encoding both lead back to IDLE.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. start matters only in IDLE; DONE always lasts one cycle.
   always_comb begin
      w_nextState = IDLE;
      case (r_state)
         IDLE:    w_nextState = i_start ? CONVERT : IDLE;
         CONVERT: w_nextState = w_lastIter ? DONE : CONVERT;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Datapath registers. The operand is loaded on acceptance, one bit is
   // processed per CONVERT cycle, and the result is published on the last one.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_shiftReg <= '0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_bcd      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_shiftReg <= i_bin;
                  r_acc      <= '0;
                  r_cnt      <= CNTW'(WIDTH);
               end
            end
            CONVERT: begin
               r_shiftReg <= r_shiftReg << 1;
               r_acc      <= w_accShift;
               r_cnt      <= r_cnt - CNTW'(1);
               if (w_lastIter) begin
                  r_bcd <= w_accShift;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Handshake outputs are decoded from the state register alone, so start
   // never reaches them combinationally.
   assign o_busy = (r_state == CONVERT) || (r_state == DONE);
   assign o_done = (r_state == DONE);
   assign o_bcd  = r_bcd;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// tb_binary_to_bcd_seq
// Scoreboard bench for binary_to_bcd_seq. Stimulus pushes the expected BCD
// word when it issues a request. A monitor pops and compares on every done,
// and between done pulses it checks that bcd holds its last value.

module tb_binary_to_bcd_seq;

   localparam int WIDTH  = 8;
   localparam int DIGITS = 3;

   logic              i_clk;
   logic              i_rst;
   logic              i_start;
   logic [WIDTH-1:0]  i_bin;
   logic              o_busy;
   logic              o_done;
   logic [11:0]       o_bcd;

   logic [11:0] expQ[$];
   logic [11:0] lastBcd;
   int          compared;
   int          mismatched;

   binary_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (i_start),
      .i_bin   (i_bin),
      .o_busy  (o_busy),
      .o_done  (o_done),
      .o_bcd   (o_bcd)
   );

   // Free-running 10-time-unit clock
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Reference model: hundreds, tens and units digits packed as BCD
   function automatic logic [11:0] toBcd(input int v);
      logic [3:0] h, t, u;
      h = 4'((v / 100) % 10);
      t = 4'((v / 10) % 10);
      u = 4'(v % 10);
      return {h, t, u};
   endfunction

   // Single comparison point: counts every check and reports any miss
   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Monitor: pops the scoreboard on done and checks that bcd holds otherwise
   always @(negedge i_clk) begin
      if (i_rst) begin
         lastBcd = '0;
      end else if (o_done) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedDone", 1, 0);
         end else begin
            checkOutput("bcdResult", int'(o_bcd), int'(expQ.pop_front()));
         end
         lastBcd = o_bcd;
      end else begin
         checkOutput("bcdHold", int'(o_bcd), int'(lastBcd));
      end
   end

   // Waits (bounded) for the converter to go idle, then pulses start for one cycle
   task automatic applyStimulus(input logic [7:0] value, input bit pushExp, input logic [11:0] expVal);
      int n;
      n = 0;
      while (o_busy && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      if (n >= 50) checkOutput("idleTimeout", 1, 0);
      i_bin   = value;
      i_start = 1'b1;
      if (pushExp) expQ.push_back(expVal);
      @(negedge i_clk);
      i_start = 1'b0;
      i_bin   = ~value;
   endtask

   typedef struct {
      logic [7:0]  value;
      logic [11:0] expected;
   } vec_t;

   vec_t boundaries[5];

   initial begin
      int busyCount, doneCount, doneAt, n;
      logic [7:0] heldVal;

      compared   = 0;
      mismatched = 0;
      lastBcd    = '0;
      i_rst      = 1'b1;
      i_start    = 1'b0;
      i_bin      = '0;

      boundaries[0] = '{8'd0,   12'h000};
      boundaries[1] = '{8'd9,   12'h009};
      boundaries[2] = '{8'd10,  12'h010};
      boundaries[3] = '{8'd99,  12'h099};
      boundaries[4] = '{8'd100, 12'h100};

      repeat (3) @(negedge i_clk);
      i_rst = 1'b0;
      checkOutput("resetBusy", int'(o_busy), 0);
      checkOutput("resetDone", int'(o_done), 0);
      checkOutput("resetBcd",  int'(o_bcd),  0);

      // Latency and busy width for bin=255
      $display("[TB] latency check with bin=255");
      applyStimulus(8'd255, 1'b1, 12'h255);
      busyCount = 0;
      doneCount = 0;
      doneAt    = -1;
      for (int c = 0; c < 16; c++) begin
         if (o_busy) busyCount++;
         if (o_done) begin
            doneCount++;
            doneAt = c;
         end
         @(negedge i_clk);
      end
      checkOutput("busyCycles", busyCount, WIDTH + 1);
      checkOutput("donePulses", doneCount, 1);
      checkOutput("doneLatency", doneAt, WIDTH);

      // Decimal boundaries back-to-back
      $display("[TB] boundary vectors");
      foreach (boundaries[i]) applyStimulus(boundaries[i].value, 1'b1, boundaries[i].expected);

      // Exhaustive sweep against the reference model
      $display("[TB] exhaustive sweep");
      for (int v = 0; v < 256; v++) applyStimulus(8'(v), 1'b1, toBcd(v));

      // start held high while bin changes every cycle
      $display("[TB] held start");
      n = 0;
      while (o_busy && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      i_start = 1'b1;
      for (int c = 0; c < 50; c++) begin
         heldVal = 8'((c * 37 + 11) % 256);
         i_bin   = heldVal;
         if (c % (WIDTH + 2) == 0) expQ.push_back(toBcd(int'(heldVal)));
         @(negedge i_clk);
      end
      i_start = 1'b0;

      // Reset during the fourth CONVERT cycle of bin=200
      $display("[TB] mid-conversion reset");
      applyStimulus(8'd200, 1'b0, 12'h000);
      repeat (3) @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      checkOutput("postResetBusy", int'(o_busy), 0);
      checkOutput("postResetBcd",  int'(o_bcd),  0);
      repeat (15) @(negedge i_clk);
      applyStimulus(8'd200, 1'b1, 12'h200);

      // A start pulse during DONE must be dropped
      $display("[TB] start during DONE");
      applyStimulus(8'd123, 1'b1, 12'h123);
      repeat (WIDTH) @(negedge i_clk);
      checkOutput("doneBeforePulse", int'(o_done), 1);
      i_start = 1'b1;
      i_bin   = 8'd77;
      @(negedge i_clk);
      i_start = 1'b0;
      for (int c = 0; c < 12; c++) begin
         checkOutput("busyAfterDoneStart", int'(o_busy), 0);
         @(negedge i_clk);
      end

      // Drain the scoreboard
      n = 0;
      while (expQ.size() != 0 && n < 200) begin
         @(negedge i_clk);
         n++;
      end
      checkOutput("scoreboardEmpty", expQ.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
